pc_fetch_ctrl: RTL

- Initiator/controller for the program-counter register. It drives the PC block's select and jump-address inputs, and reads back the PC's current and incremented values.
- Sequences instruction fetches from instruction memory using a req/ack handshake.
- Presents each fetched instruction downstream on a valid/ready handshake.
- Applies taken-branch redirects, and supports halt/resume.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_reg.sv | 37 +++
 rtl/pc_fetch_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter block and its fetch controller.
package pc_pkg;

   localparam logic [1:0] PC_RESET = 2'b00;
   localparam logic [1:0] PC_HOLD  = 2'b01;
   localparam logic [1:0] PC_PLUS4 = 2'b10;
   localparam logic [1:0] PC_JUMP  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      ISSUE,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: reset/hold/plus4/jump under a 2-bit select, with PC+4 output.
module pc_reg
   import pc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   sel,
   input  logic [W-1:0] pc_i,
   output logic [W-1:0] pc_o,
   output logic [W-1:0] pcinc_o
);

   logic [W-1:0] pc_q, pc_d;

   // PLUS4 wraps naturally at 2^W.
   assign pcinc_o = pc_q + W'(4);
   assign pc_o    = pc_q;

   always_comb begin
      pc_d = pc_q;
      case (sel)
         PC_RESET: pc_d = '0;
         PC_HOLD:  pc_d = pc_q;
         PC_PLUS4: pc_d = pcinc_o;
         PC_JUMP:  pc_d = pc_i;
         default:  pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: drives the PC block, fetches over req/ack, issues over valid/ready,
// and applies branch redirects and halt/resume.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int W  = 8,
   parameter int IW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          halt,
   input  logic [W-1:0]  pc_cur,
   input  logic [W-1:0]  pc_nxt,
   output logic [1:0]    pc_sel,
   output logic [W-1:0]  pc_jmp,
   output logic          imem_req,
   output logic [W-1:0]  imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_data,
   output logic          instr_valid,
   output logic [IW-1:0] instr_data,
   output logic [W-1:0]  instr_pc,
   output logic [W-1:0]  instr_pc_inc,
   input  logic          instr_ready,
   input  logic          br_taken,
   input  logic [W-1:0]  br_target,
   output logic          misalign_err
);

   fetch_state_t  state_q, state_d;
   logic          halt_pend_q, halt_pend_d;
   logic          valid_q, valid_d;
   logic [IW-1:0] data_q, data_d;
   logic [W-1:0]  ipc_q, ipc_d;
   logic [W-1:0]  inc_q, inc_d;
   logic          mis_q, mis_d;

   logic accept;
   logic misaligned;

   assign accept     = valid_q & instr_ready;
   assign misaligned = br_target[1:0] != 2'b00;

   always_comb begin
      state_d     = state_q;
      halt_pend_d = halt_pend_q;
      valid_d     = valid_q;
      data_d      = data_q;
      ipc_d       = ipc_q;
      inc_d       = inc_q;
      mis_d       = mis_q;
      pc_sel      = PC_HOLD;
      pc_jmp      = '0;
      imem_req    = 1'b0;
      imem_addr   = '0;
      case (state_q)
         IDLE: begin
            pc_sel = PC_RESET;
            if (start) state_d = FETCH;
         end
         FETCH: begin
            imem_req  = 1'b1;
            imem_addr = pc_cur;
            if (halt) halt_pend_d = 1'b1;
            if (imem_ack) begin
               data_d  = imem_data;
               ipc_d   = pc_cur;
               inc_d   = pc_nxt;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (halt) halt_pend_d = 1'b1;
            if (accept) begin
               valid_d = 1'b0;
               // A misaligned redirect is refused outright: PC held, controller parks.
               if (br_taken && misaligned) begin
                  mis_d   = 1'b1;
                  state_d = HALTED;
               end else begin
                  if (br_taken) begin
                     pc_sel = PC_JUMP;
                     pc_jmp = br_target;
                  end else begin
                     pc_sel = PC_PLUS4;
                  end
                  // halt in the accept cycle itself still counts.
                  state_d = (halt_pend_q || halt) ? HALTED : FETCH;
               end
               if (state_d == HALTED) halt_pend_d = 1'b0;
            end
         end
         HALTED: begin
            if (start) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         halt_pend_q <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         ipc_q       <= '0;
         inc_q       <= '0;
         mis_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         halt_pend_q <= halt_pend_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         ipc_q       <= ipc_d;
         inc_q       <= inc_d;
         mis_q       <= mis_d;
      end
   end

   assign instr_valid  = valid_q;
   assign instr_data   = data_q;
   assign instr_pc     = ipc_q;
   assign instr_pc_inc = inc_q;
   assign misalign_err = mis_q;

endmodule
